spi_mem_req_sequencer: RTL and testbench

Request-queueing front end placed directly upstream of the SPI memory top level (controller + memory pair). Accepts byte read/write requests on a valid/ready channel, buffers them, and issues them one at a time to the downstream `wr/addr/din` port. It holds the downstream block in reset between operations and returns read data and error/timeout status on a valid/ready response channel.

---
 rtl/spi_mem_seq_pkg.sv | 25 ++
 rtl/spi_mem_req_fifo.sv | 56 +++++
 rtl/spi_mem_req_sequencer.sv | 115 +++++++++++
 tb/tb_spi_mem_req_sequencer.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_mem_seq_pkg.sv
// Shared types and defaults for the SPI memory request sequencer.
package spi_mem_seq_pkg;

    localparam int unsigned DEFAULT_DEPTH   = 4;
    localparam int unsigned DEFAULT_TIMEOUT = 1024;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] data;
    } req_t;

    typedef struct packed {
        logic [7:0] rdata;
        logic       err;
        logic       timeout;
    } rsp_t;

endpackage

// File: rtl/spi_mem_req_fifo.sv
// Request FIFO with combinational head read; push is refused when full, pop when empty.
module spi_mem_req_fifo
    import spi_mem_seq_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_push,
    input  req_t                   i_data,
    input  logic                   i_pop,
    output req_t                   o_head,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    req_t          r_mem [DEPTH];
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wptr] <= i_data;
    end

    assign o_head  = r_mem[r_rptr];
    assign o_level = r_count;

endmodule

// File: rtl/spi_mem_req_sequencer.sv
// Queues byte requests and runs them one at a time against the SPI memory block,
// holding it in reset between operations and returning data/status on a response channel.
module spi_mem_req_sequencer
    import spi_mem_seq_pkg::*;
#(
    parameter int unsigned DEPTH   = DEFAULT_DEPTH,
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_req_valid,
    output logic                   o_req_ready,
    input  logic                   i_req_wr,
    input  logic [7:0]             i_req_addr,
    input  logic [7:0]             i_req_wdata,
    output logic                   o_rsp_valid,
    input  logic                   i_rsp_ready,
    output logic [7:0]             o_rsp_rdata,
    output logic                   o_rsp_err,
    output logic                   o_rsp_timeout,
    output logic                   o_mem_rst,
    output logic                   o_mem_wr,
    output logic [7:0]             o_mem_addr,
    output logic [7:0]             o_mem_din,
    input  logic [7:0]             i_mem_dout,
    input  logic                   i_mem_done,
    input  logic                   i_mem_err,
    output logic                   o_busy,
    output logic [$clog2(DEPTH):0] o_level
);

    localparam int unsigned CW = $clog2(TIMEOUT);

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    rsp_t          r_rsp;
    req_t          r_mem_req;
    req_t          w_req;
    req_t          w_head;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_tmo;

    assign w_req  = {i_req_wr, i_req_addr, i_req_wdata};
    assign w_push = i_req_valid && !w_full;
    // Head leaves the FIFO only once its response has been consumed.
    assign w_pop  = (r_state == RESP) && i_rsp_ready;
    assign w_tmo  = (r_cnt == CW'(TIMEOUT - 1));

    spi_mem_req_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_data  (w_req),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (o_level)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_rsp     <= '0;
            r_mem_req <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_empty) begin
                        r_mem_req <= w_head;
                        r_cnt     <= '0;
                        r_state   <= RUN;
                    end
                end
                RUN: begin
                    r_cnt <= r_cnt + 1'b1;
                    // Done takes priority over a coincident timeout.
                    if (i_mem_done) begin
                        r_rsp.rdata   <= r_mem_req.wr ? 8'h00 : i_mem_dout;
                        r_rsp.err     <= i_mem_err;
                        r_rsp.timeout <= 1'b0;
                        r_state       <= RESP;
                    end else if (w_tmo) begin
                        r_rsp.rdata   <= 8'h00;
                        r_rsp.err     <= 1'b1;
                        r_rsp.timeout <= 1'b1;
                        r_state       <= RESP;
                    end
                end
                RESP: begin
                    if (i_rsp_ready) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_req_ready   = !w_full;
    assign o_rsp_valid   = (r_state == RESP);
    assign o_rsp_rdata   = r_rsp.rdata;
    assign o_rsp_err     = r_rsp.err;
    assign o_rsp_timeout = r_rsp.timeout;
    assign o_mem_rst     = (r_state != RUN);
    assign o_mem_wr      = r_mem_req.wr;
    assign o_mem_addr    = r_mem_req.addr;
    assign o_mem_din     = r_mem_req.data;
    assign o_busy        = (r_state != IDLE) || !w_empty;

endmodule

// File: tb/tb_spi_mem_req_sequencer.sv
// Directed and randomized bench for spi_mem_req_sequencer with a behavioural downstream memory.
module tb_spi_mem_req_sequencer;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid, req_ready, req_wr;
    logic [7:0] req_addr, req_wdata;
    logic       rsp_valid, rsp_ready;
    logic [7:0] rsp_rdata;
    logic       rsp_err, rsp_timeout;
    logic       mem_rst, mem_wr;
    logic [7:0] mem_addr, mem_din;
    logic [7:0] mem_dout = 8'h00;
    logic       mem_done = 1'b0;
    logic       mem_err  = 1'b0;
    logic       busy;
    logic [2:0] level;

    always #5 clk = ~clk;

    spi_mem_req_sequencer #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_req_valid   (req_valid),
        .o_req_ready   (req_ready),
        .i_req_wr      (req_wr),
        .i_req_addr    (req_addr),
        .i_req_wdata   (req_wdata),
        .o_rsp_valid   (rsp_valid),
        .i_rsp_ready   (rsp_ready),
        .o_rsp_rdata   (rsp_rdata),
        .o_rsp_err     (rsp_err),
        .o_rsp_timeout (rsp_timeout),
        .o_mem_rst     (mem_rst),
        .o_mem_wr      (mem_wr),
        .o_mem_addr    (mem_addr),
        .o_mem_din     (mem_din),
        .i_mem_dout    (mem_dout),
        .i_mem_done    (mem_done),
        .i_mem_err     (mem_err),
        .o_busy        (busy),
        .o_level       (level)
    );

    typedef struct {
        logic [7:0] rdata;
        logic       err;
        logic       tmo;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] ref_mem [256];
    logic [7:0] dev_mem [256];
    bit         dev_hang = 1'b0;
    int         tests_run = 0;
    int         tests_failed = 0;

    // Downstream device: addresses with bit 7 set report err; random latency per op.
    int          dev_lat = 0, dev_cnt = 0, hi_cnt = 0, min_gap = 999;
    bit          seen_op = 1'b0, in_op = 1'b0, unstable = 1'b0;
    logic [16:0] op_snap = '0;

    always @(negedge clk) begin
        if (mem_rst !== 1'b0) begin
            mem_done = 1'b0;
            mem_err  = 1'b0;
            in_op    = 1'b0;
            hi_cnt++;
        end else begin
            if (!in_op) begin
                if (seen_op && hi_cnt < min_gap) min_gap = hi_cnt;
                seen_op = 1'b1;
                hi_cnt  = 0;
                in_op   = 1'b1;
                dev_cnt = 0;
                dev_lat = $urandom_range(2, 8);
                op_snap = {mem_wr, mem_addr, mem_din};
            end else if (op_snap !== {mem_wr, mem_addr, mem_din}) begin
                unstable = 1'b1;
            end
            mem_done = 1'b0;
            mem_err  = 1'b0;
            if (!dev_hang && dev_cnt == dev_lat) begin
                mem_done = 1'b1;
                mem_err  = mem_addr[7];
                if (mem_wr) begin
                    dev_mem[mem_addr] = mem_din;
                    mem_dout = 8'($urandom);
                end else begin
                    mem_dout = dev_mem[mem_addr];
                end
            end
            dev_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Entered and left at a negedge; expected result follows from FIFO order.
    task automatic push(input logic wr, input logic [7:0] a, input logic [7:0] d, input bit hang);
        exp_t e;
        int   n = 0;
        while (req_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (req_ready !== 1'b1) begin
            check("push_ready", req_ready, 1);
            return;
        end
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = a;
        req_wdata = d;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        if (hang) begin
            e = '{rdata: 8'h00, err: 1'b1, tmo: 1'b1};
        end else if (wr) begin
            e = '{rdata: 8'h00, err: a[7], tmo: 1'b0};
            ref_mem[a] = d;
        end else begin
            e = '{rdata: ref_mem[a], err: a[7], tmo: 1'b0};
        end
        exp_q.push_back(e);
    endtask

    task automatic collect(input string tag);
        exp_t e;
        int   n = 0;
        while (rsp_valid !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, rsp_valid, 1);
        e = exp_q.pop_front();
        if (rsp_valid === 1'b1) begin
            check({tag, "_rdata"}, rsp_rdata, e.rdata);
            check({tag, "_err"}, rsp_err, e.err);
            check({tag, "_timeout"}, rsp_timeout, e.tmo);
            rsp_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            rsp_ready = 1'b0;
            check({tag, "_drop"}, rsp_valid, 0);
        end
    endtask

    initial begin
        logic       bw [5];
        logic [7:0] ba [5];
        logic [7:0] bd [5];
        int         n;
        int         k;

        for (int i = 0; i < 256; i++) begin
            dev_mem[i] = 8'($urandom);
            ref_mem[i] = dev_mem[i];
        end
        rst       = 1'b1;
        req_valid = 1'b0;
        req_wr    = 1'b0;
        req_addr  = 8'h00;
        req_wdata = 8'h00;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_req_ready", req_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_rsp_timeout", rsp_timeout, 0);
        check("rst_mem_rst", mem_rst, 1);
        check("rst_mem_wr", mem_wr, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_din", mem_din, 0);
        check("rst_busy", busy, 0);
        check("rst_level", level, 0);
        rst = 1'b0;
        @(negedge clk);

        // Write then read back the same address; also checks issue latency.
        push(1'b1, 8'h10, 8'hA5, 1'b0);
        check("issue_level", level, 1);
        check("issue_idle_mem_rst", mem_rst, 1);
        @(negedge clk);
        check("issue_run_mem_rst", mem_rst, 0);
        check("issue_mem_wr", mem_wr, 1);
        check("issue_mem_addr", mem_addr, 8'h10);
        check("issue_mem_din", mem_din, 8'hA5);
        push(1'b0, 8'h10, 8'h00, 1'b0);
        collect("wr10");
        collect("rd10");

        // Backpressure: fill the FIFO with responses stalled.
        for (int i = 0; i < 5; i++) begin
            bw[i] = 1'($urandom);
            ba[i] = 8'($urandom_range(0, 127));
            bd[i] = 8'($urandom);
        end
        for (int i = 0; i < 4; i++) push(bw[i], ba[i], bd[i], 1'b0);
        check("bp_req_ready", req_ready, 0);
        check("bp_level", level, 4);
        check("bp_busy", busy, 1);
        repeat (12) @(negedge clk);
        check("bp_rsp_valid", rsp_valid, 1);
        check("bp_level_hold", level, 4);
        check("bp_mem_addr", mem_addr, ba[0]);
        check("bp_mem_wr", mem_wr, bw[0]);
        collect("bp0");
        push(bw[4], ba[4], bd[4], 1'b0);
        collect("bp1");
        collect("bp2");
        collect("bp3");
        collect("bp4");

        // Downstream error, followed by further requests.
        push(1'b0, 8'h80, 8'h00, 1'b0);
        push(1'b1, 8'h20, 8'h3C, 1'b0);
        push(1'b0, 8'h20, 8'h00, 1'b0);
        collect("err80");
        collect("after_err_wr");
        collect("after_err_rd");

        // Timeout: device never answers.
        dev_hang = 1'b1;
        push(1'b0, 8'h05, 8'h00, 1'b1);
        n = 0;
        while (mem_rst !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("tmo_run_entry", mem_rst, 0);
        n = 0;
        while (rsp_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("tmo_cycles", n, TIMEOUT);
        check("tmo_mem_rst", mem_rst, 1);
        collect("tmo");
        dev_hang = 1'b0;

        // Response stall: outputs must hold and nothing new is issued.
        push(1'b0, 8'h33, 8'h00, 1'b0);
        push(1'b1, 8'h44, 8'h99, 1'b0);
        n = 0;
        while (rsp_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            check("stall_rsp_valid", rsp_valid, 1);
            check("stall_rsp_rdata", rsp_rdata, exp_q[0].rdata);
            check("stall_rsp_err", rsp_err, exp_q[0].err);
            check("stall_mem_rst", mem_rst, 1);
            check("stall_mem_addr", mem_addr, 8'h33);
            check("stall_mem_wr", mem_wr, 0);
            check("stall_level", level, 2);
            @(negedge clk);
        end
        collect("stall0");
        collect("stall1");

        // Reset mid-operation with requests queued.
        dev_hang = 1'b1;
        for (int i = 0; i < 3; i++) push(1'($urandom), 8'($urandom_range(0, 127)), 8'($urandom), 1'b1);
        n = 0;
        while (mem_rst !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("mid_run", mem_rst, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        dev_hang = 1'b0;
        check("mid_rst_level", level, 0);
        check("mid_rst_mem_rst", mem_rst, 1);
        check("mid_rst_req_ready", req_ready, 1);
        check("mid_rst_rsp_valid", rsp_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_mem_addr", mem_addr, 0);
        repeat (10) @(negedge clk);
        check("mid_rst_no_rsp", rsp_valid, 0);
        check("mid_rst_idle", busy, 0);

        // Randomized batches over the full address range.
        for (int r = 0; r < 8; r++) begin
            k = $urandom_range(1, 4);
            for (int j = 0; j < k; j++) push(1'($urandom), 8'($urandom), 8'($urandom), 1'b0);
            for (int j = 0; j < k; j++) collect("rand");
        end

        check("mem_stable_in_op", unstable, 0);
        check("mem_rst_gap_ge2", (min_gap >= 2), 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
